// File: rtl/hack_rom_loader_pkg.sv
// Shared types for the Hack serial program loader.
package hack_rom_loader_pkg;

   localparam int unsigned WORD_W = 16;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LEN_HI  = 4'd1,
      ST_LEN_LO  = 4'd2,
      ST_DATA_HI = 4'd3,
      ST_DATA_LO = 4'd4,
      ST_SUM_HI  = 4'd5,
      ST_SUM_LO  = 4'd6,
      ST_RUN     = 4'd7,
      ST_ERROR   = 4'd8
   } loader_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_SUM     = 2'd3
   } loader_err_t;

   // True while a frame is being received (CPU held, loader busy).
   function automatic logic in_load(loader_state_t s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
             (s == ST_DATA_LO) || (s == ST_SUM_HI) || (s == ST_SUM_LO);
   endfunction

endpackage

// File: rtl/hack_rom_loader_if.sv
// Byte input and instruction-memory write port of the loader.
// Handshake: there is no ready. rx_valid is a one-cycle strobe and the byte on
// rx_data is consumed in that cycle; wr_en is a one-cycle write strobe and
// wr_addr/wr_data are valid only while wr_en is high.
interface hack_rom_loader_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [15:0]           wr_data;

   modport master (
      input  rx_valid, rx_data,
      output wr_en, wr_addr, wr_data
   );

   modport slave (
      output rx_valid, rx_data,
      input  wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/hack_timeout_ctr.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT_CYCLES-1.
module hack_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = enable && (cnt_q == LAST);

   // Next count: clear wins, otherwise advance while enabled and not yet expired.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + ONE;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/hack_rom_loader.sv
// Serial program loader: packs UART bytes into 16-bit words, writes them to
// the Hack instruction memory, verifies the additive checksum and holds the
// CPU in reset until the image is known good.
module hack_rom_loader
   import hack_rom_loader_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 12,
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_req,
   hack_rom_loader_if.master     bus,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [ADDR_WIDTH:0]   word_count
);
   localparam logic [31:0]         DEPTH32 = 32'(1) << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] WC_ONE  = (ADDR_WIDTH+1)'(1);

   loader_state_t           state_q, state_d;
   loader_err_t             err_q, err_d;
   logic [7:0]              hi_q, hi_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic [WORD_W-1:0]       acc_q, acc_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0]       wr_data_q, wr_data_d;
   logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic                    busy_q, busy_d;
   logic                    cpu_reset_q, cpu_reset_d;

   logic [WORD_W-1:0]       rx_word;
   logic [ADDR_WIDTH:0]     wc_inc;
   logic                    to_expired;

   // The high byte of every field is latched; the low byte completes it.
   assign rx_word = {hi_q, bus.rx_data};
   assign wc_inc  = word_count_q + WC_ONE;

   hack_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (load_req | bus.rx_valid),
      .enable  (in_load(state_q)),
      .expired (to_expired)
   );

   // Next-state and output decode: load_req beats timeout, timeout beats rx byte.
   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      hi_d         = hi_q;
      len_d        = len_q;
      acc_d        = acc_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      done_d       = done_q;
      error_d      = error_q;

      if (load_req) begin
         state_d      = ST_LEN_HI;
         done_d       = 1'b0;
         error_d      = 1'b0;
         err_d        = ERR_NONE;
         word_count_d = '0;
         wr_addr_d    = '0;
         acc_d        = '0;
      end else if (to_expired) begin
         state_d = ST_ERROR;
         error_d = 1'b1;
         err_d   = ERR_TIMEOUT;
      end else if (bus.rx_valid) begin
         case (state_q)
            ST_LEN_HI: begin
               hi_d    = bus.rx_data;
               state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               if ((rx_word == 16'd0) || ({16'd0, rx_word} > DEPTH32)) begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
                  err_d   = ERR_LEN;
               end else begin
                  len_d   = rx_word[ADDR_WIDTH:0];
                  state_d = ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               hi_d    = bus.rx_data;
               state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               wr_en_d      = 1'b1;
               wr_data_d    = rx_word;
               wr_addr_d    = word_count_q[ADDR_WIDTH-1:0];
               word_count_d = wc_inc;
               acc_d        = acc_q + rx_word;
               // Compare the count rather than the address so a full
               // DEPTH-word image never wraps back to address 0.
               state_d      = (wc_inc == len_q) ? ST_SUM_HI : ST_DATA_HI;
            end
            ST_SUM_HI: begin
               hi_d    = bus.rx_data;
               state_d = ST_SUM_LO;
            end
            ST_SUM_LO: begin
               if (rx_word == acc_q) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
                  err_d   = ERR_SUM;
               end
            end
            default: ;
         endcase
      end

      busy_d      = in_load(state_d);
      cpu_reset_d = busy_d || (state_d == ST_ERROR);
   end

   // Loader FSM and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         err_q        <= ERR_NONE;
         hi_q         <= '0;
         len_q        <= '0;
         acc_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         word_count_q <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         busy_q       <= 1'b0;
         cpu_reset_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         hi_q         <= hi_d;
         len_q        <= len_d;
         acc_q        <= acc_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         word_count_q <= word_count_d;
         done_q       <= done_d;
         error_q      <= error_d;
         busy_q       <= busy_d;
         cpu_reset_q  <= cpu_reset_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign cpu_reset   = cpu_reset_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign err_code    = err_q;
   assign word_count  = word_count_q;
endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: frame-level model plus directed vectors.
module tb_hack_rom_loader;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int TO    = 100;
   localparam int W     = AW + 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic load_req;
   logic cpu_reset, busy, done, error;
   logic [1:0]  err_code;
   logic [AW:0] word_count;

   always #5 clk = ~clk;

   hack_rom_loader_if #(.ADDR_WIDTH(AW)) bus ();

   hack_rom_loader #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_req   (load_req),
      .bus        (bus),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code),
      .word_count (word_count)
   );

   // ---------------- scoreboard state ----------------
   int chk_cnt  = 0;
   int pass_cnt = 0;
   bit mon_en   = 1'b0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] log_q[$];
   logic [7:0]   frame_q[$];

   logic        exp_done, exp_error;
   logic [1:0]  exp_err;
   logic [AW:0] exp_wc;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endfunction

   // Frame-level model: derives the write list and final status from the bytes.
   task automatic model_frame();
      int n, sz, words;
      logic [15:0] w, sum, rx_sum;
      sz = frame_q.size();
      n = {frame_q[0], frame_q[1]};
      exp_done = 1'b0; exp_error = 1'b1; exp_wc = '0; exp_err = 2'd0;
      words = 0; sum = '0;
      if (n == 0 || n > DEPTH) begin
         exp_err = 2'd1;
      end else begin
         for (int i = 0; i < n; i++) begin
            if (3 + 2 * i < sz) begin
               w = {frame_q[2 + 2 * i], frame_q[3 + 2 * i]};
               sum += w;
               exp_q.push_back({i[AW-1:0], w});
               words++;
            end
         end
         exp_wc = words[AW:0];
         if (sz < 2 * n + 4) begin
            exp_err = 2'd2;
         end else begin
            rx_sum = {frame_q[2 * n + 2], frame_q[2 * n + 3]};
            if (rx_sum == sum) begin
               exp_done = 1'b1; exp_error = 1'b0;
            end else begin
               exp_err = 2'd3;
            end
         end
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         chk("cpu_reset_vs_flags", cpu_reset, busy | error);
         chk("done_error_exclusive", done & error, 1'b0);
         if (bus.wr_en === 1'b1) begin
            log_q.push_back({bus.wr_addr, bus.wr_data});
            chk("write_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) chk("write_addr_data", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   task automatic send_frame();
      foreach (frame_q[i]) send_byte(frame_q[i]);
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic check_status(input string tag);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_busy"}, busy, 1'b0);
      repeat (2) @(negedge clk);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_error"}, error, exp_error);
      chk({tag, "_err_code"}, err_code, exp_err);
      chk({tag, "_word_count"}, word_count, exp_wc);
      chk({tag, "_cpu_reset"}, cpu_reset, exp_error);
      chk({tag, "_writes_drained"}, exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
      chk({tag, "_wr_addr"}, bus.wr_addr, 0);
      chk({tag, "_wr_data"}, bus.wr_data, 0);
      chk({tag, "_cpu_reset"}, cpu_reset, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_err_code"}, err_code, 0);
      chk({tag, "_word_count"}, word_count, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int k;
      logic [15:0] w, s;
      logic [W-1:0] e;

      reset = 1'b1; load_req = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      // 1: good 3-word frame (0x1234 + 0xABCD + 0x0001 = 0xBE02)
      frame_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h02};
      model_frame();
      log_q.delete();
      pulse_load();
      chk("t1_busy_on_load", busy, 1'b1);
      chk("t1_cpu_held_on_load", cpu_reset, 1'b1);
      send_frame();
      check_status("t1");
      chk("t1_n_writes", log_q.size(), 3);
      e = log_q[0]; chk("t1_w0", e, {4'd0, 16'h1234});
      e = log_q[1]; chk("t1_w1", e, {4'd1, 16'hABCD});
      e = log_q[2]; chk("t1_w2", e, {4'd2, 16'h0001});
      chk("t1_done_lit", done, 1'b1);
      chk("t1_wc_lit", word_count, 3);

      // 2: bad checksum, restart from RUN
      frame_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h04};
      model_frame();
      log_q.delete();
      pulse_load();
      send_frame();
      check_status("t2");
      chk("t2_err_code_lit", err_code, 2'd3);
      chk("t2_n_writes", log_q.size(), 3);

      // 3: zero length, then length 17 > DEPTH
      log_q.delete();
      frame_q = '{8'h00, 8'h00};
      model_frame();
      pulse_load();
      send_frame();
      check_status("t3a");
      frame_q = '{8'h00, 8'h11};
      model_frame();
      pulse_load();
      send_frame();
      check_status("t3b");
      chk("t3_err_code_lit", err_code, 2'd1);
      chk("t3_n_writes", log_q.size(), 0);

      // 4: stall after the first data byte -> timeout exactly TO cycles later
      frame_q = '{8'h00, 8'h03, 8'h12};
      model_frame();
      pulse_load();
      send_frame();
      k = 0;
      while (error !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t4_timeout_cycle", k, TO);
      check_status("t4");
      frame_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h02};
      model_frame();
      pulse_load();
      send_frame();
      check_status("t4_reload");

      // 5a: load_req together with rx_valid mid-load drops the byte
      exp_q.push_back({4'd0, 16'h1122});
      pulse_load();
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
      load_req = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h33;
      @(negedge clk);
      load_req = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
      chk("t5_busy_after_abort", busy, 1'b1);
      chk("t5_wc_after_abort", word_count, 0);
      chk("t5_error_after_abort", error, 1'b0);
      frame_q = '{8'h00, 8'h01, 8'h56, 8'h78, 8'h56, 8'h78};
      model_frame();
      send_frame();
      check_status("t5");

      // 5b: reset mid-load returns every output to its reset value
      exp_q.push_back({4'd0, 16'h1122});
      pulse_load();
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      chk("t5b_wr_data_before_reset", bus.wr_data, 16'h1122);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_all_zero("t5b_reset");
      send_byte(8'h99);
      @(negedge clk);
      chk("t5b_idle_busy", busy, 1'b0);
      chk("t5b_idle_no_write", exp_q.size(), 0);

      // 6: full-depth frame, last write at address DEPTH-1
      frame_q = '{8'h00, 8'h10};
      s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w = 16'(i * 16'h0111 + 16'h0F0F);
         s += w;
         frame_q.push_back(w[15:8]);
         frame_q.push_back(w[7:0]);
      end
      frame_q.push_back(s[15:8]);
      frame_q.push_back(s[7:0]);
      model_frame();
      log_q.delete();
      pulse_load();
      send_frame();
      check_status("t6");
      chk("t6_n_writes", log_q.size(), DEPTH);
      e = log_q[log_q.size() - 1];
      chk("t6_last_addr", e[W-1:16], 15);
      chk("t6_wc_lit", word_count, 16);
      chk("t6_done_lit", done, 1'b1);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
